// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU for the 24-bit CPU.
// Processes WIDTH-bit operands DIGIT bits per clock, LSB first, and
// computes AND / OR / ADD / SLT / XOR. Operand inversion plus carry_in
// give SUB, NOR and NAND. Result and flags are registered and only
// change on the cycle that done is pulsed.
//
// Handshake: start is sampled only in IDLE or DONE. When accepted, the
// operands and controls are latched, busy is high for NDIG cycles (RUN),
// then done is high for exactly one cycle (DONE). start in RUN is ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request a new operation
//   a, b                 operands (WIDTH bits)
//   a_invert, b_invert   use ~a / ~b
//   carry_in             adder carry into bit 0
//   operation            000 AND, 001 OR, 010 ADD, 011 SLT, 100 XOR, others reserved
//   busy                 high while in RUN
//   done                 one-cycle completion pulse
//   result               registered result
//   carry_out, overflow  adder carry out of MSB / signed overflow (ADD, SLT)
//   zero                 high when the published result is 0
module alu_serial #(
    parameter int WIDTH = 24,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic             carry_in,
    input  logic [2:0]       operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    // Operand registers hold the already-inverted operands and shift right
    // by one digit per RUN cycle, so the active digit is always at bit 0.
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] work_q, work_nxt;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             cy_q;

    logic             accept, last;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s, dig_res;
    logic [WIDTH-1:0] res_fin;
    logic             cflag, vflag, ovf;

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last   = (cnt_q == LAST);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One digit of ripple-carry adder plus the bitwise ops.
    always_comb begin
        c       = '0;
        s       = '0;
        dig_res = '0;
        c[0]    = cy_q;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
        case (op_q)
            OP_AND:         dig_res = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
            OP_OR:          dig_res = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
            OP_ADD, OP_SLT: dig_res = s;
            OP_XOR:         dig_res = a_q[DIGIT-1:0] ^ b_q[DIGIT-1:0];
            default:        dig_res = '0;
        endcase
        // New digit enters at the top; after NDIG shifts digit 0 sits at bit 0.
        work_nxt = (work_q >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
    end

    // Final result and flags; only meaningful on the last digit, where
    // c[DIGIT-1] is the carry into bit WIDTH-1 and c[DIGIT] the carry out.
    always_comb begin
        ovf     = c[DIGIT-1] ^ c[DIGIT];
        res_fin = work_nxt;
        cflag   = 1'b0;
        vflag   = 1'b0;
        case (op_q)
            OP_ADD: begin
                cflag = c[DIGIT];
                vflag = ovf;
            end
            OP_SLT: begin
                res_fin = WIDTH'(s[DIGIT-1] ^ ovf);
                cflag   = c[DIGIT];
                vflag   = ovf;
            end
            OP_AND, OP_OR, OP_XOR: ;
            default: res_fin = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            cy_q      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= a_invert ? ~a : a;
                b_q    <= b_invert ? ~b : b;
                op_q   <= operation;
                cnt_q  <= '0;
                cy_q   <= carry_in;
                work_q <= '0;
            end else if (state_q == S_RUN) begin
                a_q    <= a_q >> DIGIT;
                b_q    <= b_q >> DIGIT;
                cy_q   <= c[DIGIT];
                work_q <= work_nxt;
                cnt_q  <= last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    result    <= res_fin;
                    carry_out <= cflag;
                    overflow  <= vflag;
                    zero      <= (res_fin == '0);
                end
            end
        end
    end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Digit-serial, parametrised successor to the team's 1-bit ALU slice.
- Computes AND / OR / ADD / SLT / XOR on WIDTH-bit operands, DIGIT bits per clock, LSB first. Operand inversion and an explicit carry-in give SUB, NOR and NAND.
- Uses a start/done handshake and reports carry, signed overflow and zero flags.
- Sits beside the datapath as a low-area, multi-cycle execution unit for the 24-bit CPU.

Parameters:
- WIDTH, 24, operand/result width in bits; must be at least 2.
- DIGIT, 4, bits processed per RUN cycle; must be at least 1 and must divide WIDTH exactly. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- a_invert  input  1  use ~A instead of A; latched.
- b_invert  input  1  use ~B instead of B; latched.
- carry_in  input  1  adder carry into bit 0; latched.
- operation  input  3  operation select: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 XOR, 101-111 reserved; latched.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result and flags update.
- result  output  WIDTH  registered result; holds its value until the next done.
- carry_out  output  1  carry out of the MSB (ADD/SLT only).
- overflow  output  1  signed overflow (ADD/SLT only).
- zero  output  1  high when result equals 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, result, carry_out, overflow, zero all 0. An operation in flight is discarded and no done is produced.
- States are IDLE, RUN and DONE.
  - IDLE, start=1: latch the operand and control inputs; digit counter=0; carry register=carry_in; go to RUN.
  - RUN: each edge processes digit counter (bits counter*DIGIT .. counter*DIGIT+DIGIT-1).
    - Per-bit A'/B' come from the invert flags; the logic result is written into a working shift register.
    - The ripple carry goes through DIGIT adder bits and is stored for the next digit.
    - Counter increments each edge. On the edge where counter=NDIG-1, go to DONE and update result and flags.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted as in IDLE (back-to-back, straight to RUN).
    - Otherwise go to IDLE.
- Latency: start accepted on edge k; done is high in the cycle after edge k+NDIG. Throughput is one operation per NDIG+1 cycles.
- start in RUN is ignored. Input changes after acceptance have no effect.
- busy=1 exactly in RUN. result and flags do not change during RUN; the working register is internal.
- Flags at completion:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. Capture the carry into the MSB inside the last digit.
- SLT: the adder runs exactly as for ADD. The final result is {WIDTH-1 zeros, sum[WIDTH-1] XOR overflow}. carry_out and overflow report the subtraction.
- AND/OR/XOR: carry_out=0, overflow=0.
- Reserved ops: result=0, carry_out=0, overflow=0, zero=1.
- zero is evaluated on the final published result for every op.
- DIGIT=WIDTH is legal: NDIG=1, one RUN cycle.

Test Plan:
- ADD: WIDTH=24, DIGIT=4; a=0x000001, b=0xFFFFFF, carry_in=0, op=010 -> done 6 cycles after the accepting edge; busy high for 6 cycles; result=0x000000, carry_out=1, overflow=0, zero=1.
- SUB: a=0x7FFFFF, b=0xFFFFFF, b_invert=1, carry_in=1, op=010 -> result=0x800000, overflow=1, carry_out=0, zero=0.
- SLT: a=0xFFFFFE, b=0x000003, b_invert=1, carry_in=1, op=011 -> result=0x000001. Swap the operands -> result=0x000000, zero=1.
- NOR: a=0x0F0F0F, b=0x00FF00, a_invert=1, b_invert=1, op=000 -> result=0xF000F0, carry_out=0, overflow=0.
- Handshake: pulse start again during RUN -> ignored and result unchanged. Assert start in the DONE cycle -> new operation begins, done recurs 7 cycles after the first done. Inputs changed mid-RUN -> no effect.
- Reset and parameter sweep:
  - Assert rst_n=0 in the 3rd RUN cycle -> all outputs 0 immediately, no done. After release, the next start runs normally.
  - Repeat the ADD/SUB cases with DIGIT=1 (24-cycle latency) and DIGIT=24 (1-cycle latency) -> identical results.
